// File: rtl/otter_mem_arb_pkg.sv
// otter_mem_arb_pkg: shared types and constants for the OTTER data-port arbiter.
package otter_mem_arb_pkg;

  typedef enum logic [1:0] {
    NORMAL = 2'd0,
    STARVE = 2'd1,
    LOCKED = 2'd2
  } arb_state_t;

  typedef enum logic {
    CPU = 1'b0,
    DBG = 1'b1
  } owner_t;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

endpackage

// File: rtl/otter_arb_starve_ctr.sv
// otter_arb_starve_ctr: saturating count of cycles the debug requester waited.
// hit flags that the count reaches the limit on the coming edge, so the
// arbiter can hand DBG priority in the very next cycle.
module otter_arb_starve_ctr #(
  parameter int MAX_WAIT = 8
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic starve,
  input  logic clr,
  output logic hit
);

  localparam logic [7:0] LIMIT = 8'(MAX_WAIT);

  logic [7:0] count;
  logic [7:0] count_nxt;

  // Next count: clear wins, otherwise step up while starved until saturated.
  always_comb begin
    count_nxt = count;
    if (clr) begin
      count_nxt = '0;
    end else if (starve && (count != LIMIT)) begin
      count_nxt = count + 8'd1;
    end
  end

  assign hit = (count_nxt == LIMIT);

  // Count register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      count <= '0;
    end else begin
      count <= count_nxt;
    end
  end

endmodule

// File: rtl/otter_mem_arbiter.sv
// otter_mem_arbiter: two-requester (CPU, debug/loader) arbiter for the OTTER
// memory data port, with starvation relief for DBG and 1-cycle read return.
// Optional bus lock for the debug requester: define MEM_ARB_LOCK_EN.
//
//   state  | meaning
//   NORMAL | CPU wins when both request; DBG wait cycles are counted
//   STARVE | DBG waited MAX_WAIT cycles and now wins
//   LOCKED | DBG holds the bus; CPU is never granted
module otter_mem_arbiter
  import otter_mem_arb_pkg::*;
#(
  parameter int MAX_WAIT = 8
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        CPU_REQ,
  input  logic        CPU_WE,
  input  logic        CPU_SIGN,
  input  logic [31:0] CPU_ADDR,
  input  logic [31:0] CPU_DIN,
  input  logic [1:0]  CPU_SIZE,
  output logic        CPU_GNT,
  output logic        CPU_RVALID,
  input  logic        DBG_REQ,
  input  logic        DBG_WE,
  input  logic        DBG_SIGN,
  input  logic [31:0] DBG_ADDR,
  input  logic [31:0] DBG_DIN,
  input  logic [1:0]  DBG_SIZE,
  output logic        DBG_GNT,
  output logic        DBG_RVALID,
  input  logic        DBG_LOCK,
  output logic [31:0] RDATA,
  output logic [31:0] MEM_ADDR2,
  output logic [31:0] MEM_DIN2,
  output logic [1:0]  MEM_SIZE,
  output logic        MEM_SIGN,
  output logic        MEM_WRITE2,
  output logic        MEM_READ2,
  input  logic [31:0] MEM_DOUT2
);

  arb_state_t state;
  logic       pend_valid;
  owner_t     pend_owner;
  logic       starve_hit;
  logic       lock_take;
  logic       dbg_starved;
  logic       starve_clr;

  // Grant from current state and requests; forced low while in reset.
  always_comb begin
    CPU_GNT = 1'b0;
    DBG_GNT = 1'b0;
    if (RST_N) begin
      case (state)
        LOCKED: DBG_GNT = DBG_REQ;
        STARVE: begin
          DBG_GNT = DBG_REQ;
          CPU_GNT = CPU_REQ & ~DBG_REQ;
        end
        default: begin
          CPU_GNT = CPU_REQ;
          DBG_GNT = DBG_REQ & ~CPU_REQ;
        end
      endcase
    end
  end

  // Memory command follows the granted requester; idle bus drives zeros.
  always_comb begin
    MEM_ADDR2  = '0;
    MEM_DIN2   = '0;
    MEM_SIZE   = '0;
    MEM_SIGN   = 1'b0;
    MEM_WRITE2 = 1'b0;
    MEM_READ2  = 1'b0;
    if (CPU_GNT) begin
      MEM_ADDR2  = CPU_ADDR;
      MEM_DIN2   = CPU_DIN;
      MEM_SIZE   = CPU_SIZE;
      MEM_SIGN   = CPU_SIGN;
      MEM_WRITE2 = CPU_WE;
      MEM_READ2  = ~CPU_WE;
    end else if (DBG_GNT) begin
      MEM_ADDR2  = DBG_ADDR;
      MEM_DIN2   = DBG_DIN;
      MEM_SIZE   = DBG_SIZE;
      MEM_SIGN   = DBG_SIGN;
      MEM_WRITE2 = DBG_WE;
      MEM_READ2  = ~DBG_WE;
    end
  end

`ifdef MEM_ARB_LOCK_EN
  assign lock_take = DBG_GNT & DBG_LOCK;
`else
  assign lock_take = 1'b0;
`endif

  assign dbg_starved = DBG_REQ & ~DBG_GNT;
  assign starve_clr  = ~DBG_REQ | DBG_GNT;

  otter_arb_starve_ctr #(
    .MAX_WAIT(MAX_WAIT)
  ) u_starve_ctr (
    .CLK   (CLK),
    .RST_N (RST_N),
    .starve(dbg_starved),
    .clr   (starve_clr),
    .hit   (starve_hit)
  );

  // Arbitration state plus owner of the read accepted on this edge.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state      <= NORMAL;
      pend_valid <= 1'b0;
      pend_owner <= CPU;
    end else begin
      pend_valid <= MEM_READ2;
      pend_owner <= CPU_GNT ? CPU : DBG;
      case (state)
        NORMAL: begin
          if (lock_take) state <= LOCKED;
          else if (starve_hit) state <= STARVE;
        end
        STARVE: begin
          if (lock_take) state <= LOCKED;
          else if (DBG_GNT || !DBG_REQ) state <= NORMAL;
        end
        LOCKED: begin
          if (!DBG_LOCK) state <= NORMAL;
        end
        default: state <= NORMAL;
      endcase
    end
  end

  assign CPU_RVALID = pend_valid & (pend_owner == CPU);
  assign DBG_RVALID = pend_valid & (pend_owner == DBG);
  assign RDATA      = pend_valid ? MEM_DOUT2 : '0;

endmodule
